// File: rtl/int_mult_arb_pkg.sv
// ============================================================================
// Module  : int_mult_arb_pkg
// Brief   : Shared widths, FSM state and tag type for int_mult_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package int_mult_arb_pkg;

  localparam int MULT_A_W = 54;
  localparam int PROD_W   = 108;
  localparam int LOW_W    = 24;
  // Wide enough for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational rotate-priority one-hot select with exclude mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic [N-1:0]    excl,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [N-1:0] w_req_m;
  logic         w_found;
  int           w_idx;

  assign w_req_m = req & ~excl;

  // First requester at or after ptr, wrapping modulo N
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!w_found && w_req_m[w_idx]) begin
        w_found       = 1'b1;
        grant[w_idx]  = 1'b1;
        grant_id      = ID_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_mult_arbiter.sv
// ============================================================================
// Module  : int_mult_arbiter
// Brief   : Round-robin burst arbiter sharing one pipelined 54x54 multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int_mult_arbiter
  import int_mult_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MULT_LAT  = 5,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*MULT_A_W-1:0]   req_a,
  input  logic [NUM_REQ*MULT_A_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [MULT_A_W-1:0]           mult_a,
  output logic [MULT_A_W-1:0]           mult_b,
  input  logic [PROD_W-1:0]             int_mult_result,
  input  logic [LOW_W-1:0]              int_mult_result_low,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [PROD_W-1:0]             resp_result,
  output logic [LOW_W-1:0]              resp_low,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t          r_state;
  logic [ID_W-1:0]     r_owner;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_burst_cnt;
  tag_t                r_tag [MULT_LAT];
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [MULT_A_W-1:0] r_mult_a;
  logic [MULT_A_W-1:0] r_mult_b;

  logic [NUM_REQ-1:0]  w_owner_oh;
  logic [NUM_REQ-1:0]  w_excl;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_ready;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_next_id;
  logic [ID_W-1:0]     w_arb_ptr;
  logic [ID_W-1:0]     w_acc_id;
  logic                w_exhausted;
  logic                w_others;
  logic                w_own_cont;
  logic                w_accept;
  logic                w_tag_any;

  assign w_owner_oh  = NUM_REQ'(1) << r_owner;
  assign w_next_id   = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
  assign w_exhausted = (r_burst_cnt == CNT_W'(MAX_BURST));
  assign w_others    = |(req_valid & ~w_owner_oh);
  assign w_own_cont  = (r_state == BURST) && req_valid[r_owner] && !w_exhausted;

  // A spent owner is only pushed aside when someone else is actually waiting
  assign w_arb_ptr = (r_state == BURST) ? w_next_id : r_rr_ptr;
  assign w_excl    = ((r_state == BURST) && w_exhausted && w_others) ? w_owner_oh : '0;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (w_arb_ptr),
    .excl     (w_excl),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  assign w_ready   = w_own_cont ? w_owner_oh : w_grant;
  assign req_ready = rst_n ? w_ready : '0;
  assign w_accept  = |w_ready;
  assign w_acc_id  = w_own_cont ? r_owner : w_grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner     <= w_grant_id;
            r_burst_cnt <= CNT_W'(1);
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (w_own_cont) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end else begin
            r_rr_ptr <= w_next_id;
            if (w_accept) begin
              r_owner     <= w_grant_id;
              r_burst_cnt <= CNT_W'(1);
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operands and tag advance together so the tail lines up with the product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_resp_valid <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_mult_a <= req_a[MULT_A_W*w_acc_id +: MULT_A_W];
        r_mult_b <= req_b[MULT_A_W*w_acc_id +: MULT_A_W];
      end
      r_tag[0].valid <= w_accept;
      r_tag[0].id    <= TAG_ID_W'(w_acc_id);
      for (int k = 1; k < MULT_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      r_resp_valid <= r_tag[MULT_LAT-1].valid ?
                      (NUM_REQ'(1) << r_tag[MULT_LAT-1].id) : '0;
    end
  end

  always_comb begin
    w_tag_any = 1'b0;
    for (int k = 0; k < MULT_LAT; k++) begin
      w_tag_any = w_tag_any | r_tag[k].valid;
    end
  end

  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;
  assign resp_valid  = r_resp_valid;
  assign resp_result = int_mult_result;
  assign resp_low    = int_mult_result_low;
  assign busy        = rst_n & ((|req_valid) | w_tag_any | (|r_resp_valid));

endmodule

`default_nettype wire
